multi_period_meter: RTL and testbench
=====================================

Name: multi_period_meter

Overview:
- Multi-channel, parametrised successor to the single-channel period counter used in the PLL benches.
- Measures the period of up to CHANNELS asynchronous clock-like inputs, in cycles of the reference clock clk, averaged over 2^AVG_LOG2 periods.
- Flags per-channel lock against a programmable expected period with tolerance, and detects overflow on stopped clocks.
- Sits beside PLL instances in benches and FPGA self-test to qualify CLKOUTn/CLKFBOUT.

Parameters:
CHANNELS, 6, number of measured inputs
CNT_WIDTH, 16, width of per-period cycle counter and of each reported period
AVG_LOG2, 3, log2 of periods averaged per measurement window
TOL, 1, allowed absolute deviation (clk cycles) from expected for a lock match
LOCK_COUNT, 4, consecutive matching windows required to assert locked
SYNC_STAGES, 2, synchroniser flops per channel (min 2)

Ports:
clk  input  1  reference clock, all logic on rising edge
RST  input  1  asynchronous active-low reset
en  input  1  measurement enable, level
sig_in  input  CHANNELS  measured signals, asynchronous to clk
expected  input  CNT_WIDTH  expected period in clk cycles, shared by all channels
period_out  output  CHANNELS*CNT_WIDTH  averaged period, channel c at bits [c*CNT_WIDTH +: CNT_WIDTH]
valid  output  CHANNELS  one-cycle pulse per channel when period_out updates
locked  output  CHANNELS  per-channel lock flag
overflow  output  CHANNELS  sticky per-channel overflow flag
all_locked  output  1  AND of locked

Behaviour:
- Reset (RST=0, asynchronous): all outputs 0, synchronisers 0, counters 0, every channel FSM in IDLE. Release is synchronous to the next clk edge.
- Edge detection: sig_in[c] passes through SYNC_STAGES flops; a rising edge is detected when sync output is 1 and the previous sample is 0. Edge-detect latency from input transition is SYNC_STAGES+1 clk cycles.
- Per-channel FSM states: IDLE, MEASURE.
  - IDLE: cyc_cnt, acc and per_cnt hold at 0. On a detected edge with en=1, go to MEASURE, cyc_cnt<=1, acc<=0, per_cnt<=0.
  - MEASURE: cyc_cnt increments each cycle. On a detected edge: sample=cyc_cnt, acc<=acc+sample, per_cnt++, cyc_cnt<=1.
- Window completion: when per_cnt reaches 2^AVG_LOG2, use acc including the current sample. period_out[c] <= acc>>AVG_LOG2 (truncate). valid[c]=1 for exactly that cycle. acc and per_cnt clear, and measuring continues without a gap.
- Widths: acc is CNT_WIDTH+AVG_LOG2 bits and cannot overflow.
- Overflow: if cyc_cnt reaches 2^CNT_WIDTH-1 with no edge:
  - overflow[c]<=1 (sticky); locked[c]<=0; lock match counter clears.
  - FSM goes to IDLE; the window is discarded and period_out holds.
  - overflow clears only on reset or en=0.
- Lock, evaluated at each valid pulse using unsigned absolute difference |avg-expected|:
  - If difference <= TOL, the match counter increments, saturating at LOCK_COUNT. locked[c] asserts in the same cycle the counter reaches LOCK_COUNT.
  - Otherwise the match counter clears and locked[c] deasserts in that cycle.
- en=0:
  - Every channel goes to IDLE next cycle; locked, overflow, valid, match counters clear; period_out holds its last value.
  - Re-enabling starts fresh: the first edge only arms the channel.
- Simultaneous events: window completion and cyc_cnt saturation cannot coincide. en=0 overrides any edge in the same cycle.
- all_locked is combinational from locked registers.

Test Plan:
1. Reset: hold RST=0 with sig_in toggling, then release. All outputs stay 0 until the first window completes. Assert RST=0 mid-window: all outputs 0 immediately, without waiting for a clk edge.
2. Steady period: default params, sig_in[0] 5 clk high / 5 low, en=1. First valid[0] occurs 80 cycles after the first detected edge, with period_out[0]=10. Subsequent valid pulses follow every 80 cycles.
3. Lock: expected=10, TOL=0. locked[0] rises on the 4th valid pulse. Switch the input to period 12: locked[0] falls on the first window with avg 12 (diff 2 > TOL).
4. Jitter averaging: input periods alternate 9,11. period_out=10, and lock holds with TOL=0. Alternating 10,11 gives avg 10 (truncation of 84/8).
5. Overflow: CNT_WIDTH=8, sig_in[1] held 0 after one edge. overflow[1]=1 255 cycles after the arming edge, locked[1]=0, period_out[1] unchanged. Restart the input: overflow stays 1 until en is pulsed low.
6. Multi-channel: periods 4, 6, 10, 20, 7, 3 on channels 0-5 with expected=10, TOL=1. Only channel 2 locks and all_locked=0. Set all inputs to period 10: all_locked=1 after 4 windows on the slowest-arming channel.

Source files
------------

// File: rtl/multi_period_meter_if.sv
// Control/status bundle of the multi-channel period meter.
// The DUT takes the slave modport and the driving bench takes the master.
interface multi_period_meter_if #(
  parameter int unsigned CHANNELS  = 6,
  parameter int unsigned CNT_WIDTH = 16
);
  logic                          en;
  logic [CHANNELS-1:0]           sig_in;
  logic [CNT_WIDTH-1:0]          expected;
  logic [CHANNELS*CNT_WIDTH-1:0] period_out;
  logic [CHANNELS-1:0]           valid;
  logic [CHANNELS-1:0]           locked;
  logic [CHANNELS-1:0]           overflow;
  logic                          all_locked;

  modport master (
    output en, sig_in, expected,
    input  period_out, valid, locked, overflow, all_locked
  );

  modport slave (
    input  en, sig_in, expected,
    output period_out, valid, locked, overflow, all_locked
  );
endinterface

// File: rtl/multi_period_meter.sv
// Per-channel period meter: synchronises each input, averages 2^AVG_LOG2 periods
// in clk cycles, tracks lock against a shared expected period and flags stopped clocks.
module multi_period_meter #(
  parameter int unsigned CHANNELS    = 6,
  parameter int unsigned CNT_WIDTH   = 16,
  parameter int unsigned AVG_LOG2    = 3,
  parameter int unsigned TOL         = 1,
  parameter int unsigned LOCK_COUNT  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic                clk,
  input logic                RST,
  multi_period_meter_if.slave bus
);

  localparam int unsigned ACC_W   = CNT_WIDTH + AVG_LOG2;
  localparam int unsigned PER_W   = AVG_LOG2 + 1;
  localparam int unsigned MATCH_W = $clog2(LOCK_COUNT + 1);

  localparam logic [CNT_WIDTH-1:0] CYC_MAX    = '1;
  localparam logic [CNT_WIDTH-1:0] TOL_W      = CNT_WIDTH'(TOL);
  localparam logic [PER_W-1:0]     PER_LAST   = PER_W'((1 << AVG_LOG2) - 1);
  localparam logic [MATCH_W-1:0]   MATCH_FULL = MATCH_W'(LOCK_COUNT);
  localparam logic [MATCH_W-1:0]   MATCH_PRE  = MATCH_W'(LOCK_COUNT - 1);

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   edge_c;
    state_t                 state_q;
    logic [CNT_WIDTH-1:0]   cyc_q;
    logic [CNT_WIDTH-1:0]   period_q;
    logic [ACC_W-1:0]       acc_q;
    logic [PER_W-1:0]       per_q;
    logic [MATCH_W-1:0]     match_q;
    logic                   valid_q;
    logic                   locked_q;
    logic                   ovf_q;
    logic [ACC_W-1:0]       acc_sum_c;
    logic [CNT_WIDTH-1:0]   avg_c;
    logic [CNT_WIDTH-1:0]   diff_c;

    // Synchroniser chain plus one delayed sample for rising-edge detection
    always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
        sync_q <= '0;
        prev_q <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], bus.sig_in[c]};
        prev_q <= sync_q[SYNC_STAGES-1];
      end
    end

    assign edge_c    = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign acc_sum_c = acc_q + ACC_W'(cyc_q);
    assign avg_c     = CNT_WIDTH'(acc_sum_c >> AVG_LOG2);
    assign diff_c    = (avg_c >= bus.expected) ? (avg_c - bus.expected)
                                               : (bus.expected - avg_c);

    // Measurement FSM; en low forces a fresh start but keeps the last period
    always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
        state_q  <= IDLE;
        cyc_q    <= '0;
        acc_q    <= '0;
        per_q    <= '0;
        period_q <= '0;
        match_q  <= '0;
        valid_q  <= 1'b0;
        locked_q <= 1'b0;
        ovf_q    <= 1'b0;
      end else if (!bus.en) begin
        state_q  <= IDLE;
        cyc_q    <= '0;
        acc_q    <= '0;
        per_q    <= '0;
        match_q  <= '0;
        valid_q  <= 1'b0;
        locked_q <= 1'b0;
        ovf_q    <= 1'b0;
      end else begin
        valid_q <= 1'b0;
        case (state_q)
          IDLE: begin
            if (edge_c) begin
              state_q <= MEASURE;
              cyc_q   <= CNT_WIDTH'(1);
              acc_q   <= '0;
              per_q   <= '0;
            end
          end
          MEASURE: begin
            if (edge_c) begin
              cyc_q <= CNT_WIDTH'(1);
              if (per_q == PER_LAST) begin
                period_q <= avg_c;
                valid_q  <= 1'b1;
                acc_q    <= '0;
                per_q    <= '0;
                if (diff_c <= TOL_W) begin
                  if (match_q >= MATCH_PRE) begin
                    match_q  <= MATCH_FULL;
                    locked_q <= 1'b1;
                  end else begin
                    match_q <= match_q + MATCH_W'(1);
                  end
                end else begin
                  match_q  <= '0;
                  locked_q <= 1'b0;
                end
              end else begin
                acc_q <= acc_sum_c;
                per_q <= per_q + PER_W'(1);
              end
            end else if (cyc_q == CYC_MAX) begin
              // Stopped input: drop the partial window and wait for a new arming edge
              ovf_q    <= 1'b1;
              locked_q <= 1'b0;
              match_q  <= '0;
              state_q  <= IDLE;
              cyc_q    <= '0;
              acc_q    <= '0;
              per_q    <= '0;
            end else begin
              cyc_q <= cyc_q + CNT_WIDTH'(1);
            end
          end
        endcase
      end
    end

    assign bus.period_out[c*CNT_WIDTH +: CNT_WIDTH] = period_q;
    assign bus.valid[c]    = valid_q;
    assign bus.locked[c]   = locked_q;
    assign bus.overflow[c] = ovf_q;
  end

  assign bus.all_locked = &bus.locked;

endmodule

// File: tb/tb_multi_period_meter.sv
// Directed bench for multi_period_meter: dut_a (8-bit counters, TOL=0) covers
// reset, averaging, lock and overflow; dut_b (defaults, TOL=1) covers multi-channel lock.
module tb_multi_period_meter;
  localparam int CH = 6;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc_count = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  int   per_a [CH];
  int   per_b [CH];
  int   cnt   [CH];
  bit   sel   [CH];
  bit   hold_lvl [CH];
  logic [CH-1:0] gen_sig;

  multi_period_meter_if #(.CHANNELS(CH), .CNT_WIDTH(8))  ifa ();
  multi_period_meter_if #(.CHANNELS(CH), .CNT_WIDTH(16)) ifb ();

  multi_period_meter #(.CHANNELS(CH), .CNT_WIDTH(8), .AVG_LOG2(3), .TOL(0),
                       .LOCK_COUNT(4), .SYNC_STAGES(2))
    dut_a (.clk(clk), .RST(rst_n), .bus(ifa));

  multi_period_meter #(.CHANNELS(CH), .CNT_WIDTH(16), .AVG_LOG2(3), .TOL(1),
                       .LOCK_COUNT(4), .SYNC_STAGES(2))
    dut_b (.clk(clk), .RST(rst_n), .bus(ifb));

  assign ifa.sig_in = gen_sig;
  assign ifb.sig_in = gen_sig;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_count <= cyc_count + 1;

  // Clock-like input generator, updated on the falling edge; period 0 holds hold_lvl
  initial begin
    int cur;
    gen_sig = '0;
    forever begin
      @(negedge clk);
      for (int c = 0; c < CH; c++) begin
        cur = sel[c] ? per_b[c] : per_a[c];
        if (cur <= 0) begin
          gen_sig[c] = hold_lvl[c];
          cnt[c] = 0;
          sel[c] = 1'b0;
        end else begin
          if (cnt[c] >= cur) cnt[c] = 0;
          gen_sig[c] = (cnt[c] < cur / 2);
          cnt[c]++;
          if (cnt[c] >= cur) begin
            cnt[c] = 0;
            sel[c] = ~sel[c];
          end
        end
      end
    end
  end

  task automatic set_period(input int c, input int a, input int b);
    per_a[c] = a;
    per_b[c] = b;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid_a(input int c, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk); #1;
      if (ifa.valid[c]) ok = 1'b1;
    end
  endtask

  function automatic int pa(input int c);
    return int'(ifa.period_out[c*8 +: 8]);
  endfunction

  function automatic int pb(input int c);
    return int'(ifb.period_out[c*16 +: 16]);
  endfunction

  task automatic test_reset();
    bit seen;
    bit ok;
    rst_n = 1'b0;
    ifa.en = 1'b1; ifa.expected = 8'd10;
    ifb.en = 1'b0; ifb.expected = 16'd10;
    set_period(0, 10, 10);
    step(20);
    n_cmp++;
    if (ifa.period_out !== '0 || ifa.valid !== '0 || ifa.locked !== '0 ||
        ifa.overflow !== '0 || ifa.all_locked !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_hold: period_out=%h valid=%b locked=%b ovf=%b all=%b, want all zero",
               ifa.period_out, ifa.valid, ifa.locked, ifa.overflow, ifa.all_locked);
    end
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (ifa.valid !== '0 || ifa.period_out !== '0) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_early_output: got activity before first window, want none");
    end
    wait_valid_a(0, 120, ok);
    n_cmp++;
    if (ok !== 1'b1 || pa(0) !== 10) begin
      n_bad++;
      $display("FAIL reset_first_window: ok=%0d period=%0d want ok=1 period=10", ok, pa(0));
    end
    step(20);
    #3 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (ifa.period_out !== '0 || ifa.valid !== '0) begin
      n_bad++;
      $display("FAIL reset_async: period_out=%h valid=%b, want 0 without clk edge",
               ifa.period_out, ifa.valid);
    end
  endtask

  task automatic test_steady();
    int k, v1, v2;
    bit ok;
    set_period(0, 0, 0);
    step(3);
    rst_n = 1'b1;
    step(5);
    k = cyc_count;
    set_period(0, 10, 10);
    wait_valid_a(0, 120, ok);
    v1 = cyc_count;
    n_cmp++;
    if (ok !== 1'b1 || v1 - k !== 83) begin
      n_bad++;
      $display("FAIL steady_latency: ok=%0d cycles=%0d want 83 (3 sync/edge + 80)", ok, v1 - k);
    end
    n_cmp++;
    if (pa(0) !== 10) begin
      n_bad++;
      $display("FAIL steady_value: period=%0d want 10", pa(0));
    end
    for (int p = 0; p < 2; p++) begin
      wait_valid_a(0, 120, ok);
      v2 = cyc_count;
      n_cmp++;
      if (ok !== 1'b1 || v2 - v1 !== 80 || pa(0) !== 10) begin
        n_bad++;
        $display("FAIL steady_spacing%0d: ok=%0d gap=%0d period=%0d want gap 80 period 10",
                 p, ok, v2 - v1, pa(0));
      end
      v1 = v2;
    end
    n_cmp++;
    if (ifa.locked[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL lock_not_yet: locked=%b after 3 windows, want 0", ifa.locked[0]);
    end
  endtask

  task automatic test_lock();
    bit ok;
    bit found;
    wait_valid_a(0, 120, ok);
    n_cmp++;
    if (ok !== 1'b1 || ifa.locked[0] !== 1'b1 || ifa.all_locked !== 1'b0) begin
      n_bad++;
      $display("FAIL lock_rise: ok=%0d locked=%b all=%b want locked=1 all=0",
               ok, ifa.locked[0], ifa.all_locked);
    end
    set_period(0, 12, 12);
    found = 1'b0;
    for (int p = 0; p < 4 && !found; p++) begin
      wait_valid_a(0, 150, ok);
      if (ok && pa(0) == 12) found = 1'b1;
    end
    n_cmp++;
    if (found !== 1'b1 || ifa.locked[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL lock_fall: found12=%0d locked=%b want found12=1 locked=0",
               found, ifa.locked[0]);
    end
    wait_valid_a(0, 150, ok);
    n_cmp++;
    if (ok !== 1'b1 || pa(0) !== 12 || ifa.locked[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL lock_p12: period=%0d locked=%b want 12 / 0", pa(0), ifa.locked[0]);
    end
  endtask

  task automatic test_jitter();
    bit ok;
    set_period(0, 9, 11);
    wait_valid_a(0, 150, ok);
    wait_valid_a(0, 150, ok);
    for (int p = 0; p < 4; p++) begin
      wait_valid_a(0, 150, ok);
      n_cmp++;
      if (ok !== 1'b1 || pa(0) !== 10) begin
        n_bad++;
        $display("FAIL jitter_9_11_w%0d: ok=%0d period=%0d want 10", p, ok, pa(0));
      end
    end
    n_cmp++;
    if (ifa.locked[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL jitter_lock: locked=%b want 1", ifa.locked[0]);
    end
    set_period(0, 10, 11);
    for (int p = 0; p < 3; p++) begin
      wait_valid_a(0, 150, ok);
      n_cmp++;
      if (ok !== 1'b1 || pa(0) !== 10 || ifa.locked[0] !== 1'b1) begin
        n_bad++;
        $display("FAIL jitter_10_11_w%0d: period=%0d locked=%b want 10 / 1",
                 p, pa(0), ifa.locked[0]);
      end
    end
  endtask

  task automatic test_overflow();
    bit ok;
    set_period(1, 10, 10);
    wait_valid_a(1, 150, ok);
    set_period(1, 0, 0);
    hold_lvl[1] = 1'b0;
    n_cmp++;
    if (ok !== 1'b1 || pa(1) !== 10) begin
      n_bad++;
      $display("FAIL ovf_setup: ok=%0d period1=%0d want 10", ok, pa(1));
    end
    step(254);
    n_cmp++;
    if (ifa.overflow[1] !== 1'b0) begin
      n_bad++;
      $display("FAIL ovf_early: overflow1=%b at 254 cycles, want 0", ifa.overflow[1]);
    end
    step(1);
    n_cmp++;
    if (ifa.overflow[1] !== 1'b1 || ifa.locked[1] !== 1'b0 || pa(1) !== 10) begin
      n_bad++;
      $display("FAIL ovf_set: overflow1=%b locked1=%b period1=%0d want 1/0/10",
               ifa.overflow[1], ifa.locked[1], pa(1));
    end
    set_period(1, 10, 10);
    step(100);
    n_cmp++;
    if (ifa.overflow[1] !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_sticky: overflow1=%b want 1", ifa.overflow[1]);
    end
    ifa.en = 1'b0;
    step(1);
    n_cmp++;
    if (ifa.overflow !== '0 || ifa.locked !== '0 || pa(0) !== 10 || pa(1) !== 10) begin
      n_bad++;
      $display("FAIL en_low: ovf=%b locked=%b p0=%0d p1=%0d want 0/0/10/10",
               ifa.overflow, ifa.locked, pa(0), pa(1));
    end
    ifa.en = 1'b1;
  endtask

  task automatic test_multi();
    int exp_p [CH];
    bit ok;
    exp_p = '{4, 6, 10, 20, 7, 3};
    ifb.en = 1'b1;
    for (int c = 0; c < CH; c++) set_period(c, exp_p[c], exp_p[c]);
    step(900);
    n_cmp++;
    if (ifb.locked !== 6'b000100 || ifb.all_locked !== 1'b0) begin
      n_bad++;
      $display("FAIL multi_locked: locked=%b all=%b want 000100 / 0", ifb.locked, ifb.all_locked);
    end
    for (int c = 0; c < CH; c++) begin
      n_cmp++;
      if (pb(c) !== exp_p[c]) begin
        n_bad++;
        $display("FAIL multi_period_ch%0d: got %0d want %0d", c, pb(c), exp_p[c]);
      end
    end
    for (int c = 0; c < CH; c++) set_period(c, 10, 10);
    ok = 1'b0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      step(1);
      if (ifb.all_locked) ok = 1'b1;
    end
    n_cmp++;
    if (ok !== 1'b1 || ifb.locked !== 6'b111111) begin
      n_bad++;
      $display("FAIL multi_all_locked: ok=%0d locked=%b want 1 / 111111", ok, ifb.locked);
    end
  endtask

  initial begin
    test_reset();
    test_steady();
    test_lock();
    test_jitter();
    test_overflow();
    test_multi();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
